pc_unit: RTL and testbench

Parametrised program-counter unit for the 9-bit CPU fetch stage; it replaces the fixed 10-bit combinational incrementer with a registered PC. It supports sequential increment, absolute jump, signed relative branch, stall, and a hardware return-address stack for call and return. Its output drives instruction-memory addressing, and the control decoder drives its command inputs.

---
 rtl/pc_unit.sv | 117 +++++++++++
 tb/tb_pc_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit -- registered program counter for the fetch stage.
//
// Supports sequential increment, absolute jump, signed relative branch,
// stall, and a hardware return-address stack for call/return.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   stall      hold all state this cycle
//   jump       pc <- target
//   branch     pc <- pc + sign_extend(offset)
//   call       push pc+1, pc <- target
//   ret        pop top of stack into pc
//   target     absolute destination for jump/call
//   offset     two's-complement branch displacement
//   pc         registered current pc
//   pc_plus1   combinational (pc+1) mod 2^PC_W
//   stk_empty  stack holds no entries
//   stk_full   stack holds STACK_DEPTH entries
//   err        sticky stack overflow/underflow flag
// Command priority: rst > stall > ret > call > jump > branch > increment.
module pc_unit #(
   parameter int unsigned      PC_W        = 10,
   parameter int unsigned      OFF_W       = 8,
   parameter logic [PC_W-1:0]  RESET_PC    = '0,
   parameter int unsigned      STACK_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             jump,
   input  logic             branch,
   input  logic             call,
   input  logic             ret,
   input  logic [PC_W-1:0]  target,
   input  logic [OFF_W-1:0] offset,
   output logic [PC_W-1:0]  pc,
   output logic [PC_W-1:0]  pc_plus1,
   output logic             stk_empty,
   output logic             stk_full,
   output logic             err
);

   localparam int unsigned PW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0] pc_q, pc_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            err_q, err_d;
   logic            push_en;
   logic [IW-1:0]   wr_idx, rd_idx;
   logic [PC_W-1:0] off_ext;
   logic [PC_W-1:0] stk_q [STACK_DEPTH];

   assign pc        = pc_q;
   assign pc_plus1  = pc_q + PC_W'(1);
   assign err       = err_q;
   assign stk_empty = (ptr_q == '0);
   assign stk_full  = (ptr_q == PW'(STACK_DEPTH));

   // Sign extension via a signed size cast; the later add wraps mod 2^PC_W.
   assign off_ext = PC_W'($signed(offset));

   assign wr_idx = IW'(ptr_q);
   assign rd_idx = IW'(ptr_q - PW'(1));

   always_comb begin
      pc_d    = pc_plus1;
      ptr_d   = ptr_q;
      err_d   = err_q;
      push_en = 1'b0;
      if (stall) begin
         pc_d = pc_q;
      end else if (ret) begin
         // The array is only read when an entry exists, so an empty pop
         // never pulls an uninitialised value into the pc.
         if (!stk_empty) begin
            pc_d  = stk_q[rd_idx];
            ptr_d = ptr_q - PW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (call) begin
         pc_d = target;
         if (!stk_full) begin
            push_en = 1'b1;
            ptr_d   = ptr_q + PW'(1);
         end else begin
            err_d = 1'b1;
         end
      end else if (jump) begin
         pc_d = target;
      end else if (branch) begin
         pc_d = pc_q + off_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         ptr_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         err_q <= err_d;
      end
   end

   // Stack contents carry no reset; reset only gates the write.
   always_ff @(posedge clk) begin
      if (!rst && push_en) begin
         stk_q[wr_idx] <= pc_plus1;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

   localparam int unsigned PC_W  = 10;
   localparam int unsigned OFF_W = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MOD   = 1 << PC_W;

   logic             clk = 1'b0;
   logic             rst, stall, jump, branch, call, ret;
   logic [PC_W-1:0]  target;
   logic [OFF_W-1:0] offset;
   logic [PC_W-1:0]  pc, pc_plus1;
   logic             stk_empty, stk_full, err;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_pc;
   int m_stk[$];
   int m_err;

   always #5 clk = ~clk;

   pc_unit #(
      .PC_W(PC_W),
      .OFF_W(OFF_W),
      .RESET_PC('0),
      .STACK_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .jump(jump), .branch(branch),
      .call(call), .ret(ret), .target(target), .offset(offset),
      .pc(pc), .pc_plus1(pc_plus1), .stk_empty(stk_empty),
      .stk_full(stk_full), .err(err)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model(input bit r, s, rt, c, j, b,
                                 input int tgt, input int off);
      int o;
      if (r) begin
         m_pc = 0;
         m_stk.delete();
         m_err = 0;
      end else if (s) begin
      end else if (rt) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else begin
            m_pc  = (m_pc + 1) % MOD;
            m_err = 1;
         end
      end else if (c) begin
         if (m_stk.size() < DEPTH) m_stk.push_back((m_pc + 1) % MOD);
         else m_err = 1;
         m_pc = tgt;
      end else if (j) begin
         m_pc = tgt;
      end else if (b) begin
         o    = (off >= 128) ? off - 256 : off;
         m_pc = (m_pc + o + MOD) % MOD;
      end else begin
         m_pc = (m_pc + 1) % MOD;
      end
   endfunction

   // Drive one cycle of commands, advance the model, compare all outputs.
   task automatic step(input bit r, s, rt, c, j, b, input int tgt, input int off);
      rst = r; stall = s; ret = rt; call = c; jump = j; branch = b;
      target = PC_W'(tgt); offset = OFF_W'(off);
      @(posedge clk);
      model(r, s, rt, c, j, b, tgt, off);
      #1;
      check("pc", int'(pc), m_pc);
      check("pc_plus1", int'(pc_plus1), (m_pc + 1) % MOD);
      check("stk_empty", int'(stk_empty), int'(m_stk.size() == 0));
      check("stk_full", int'(stk_full), int'(m_stk.size() == DEPTH));
      check("err", int'(err), m_err);
   endtask

   task automatic idle();       step(0,0,0,0,0,0,0,0);   endtask
   task automatic do_jump(input int t);   step(0,0,0,0,1,0,t,0); endtask
   task automatic do_call(input int t);   step(0,0,0,1,0,0,t,0); endtask
   task automatic do_ret();     step(0,0,1,0,0,0,0,0);   endtask
   task automatic do_br(input int o);     step(0,0,0,0,0,1,0,o); endtask

   initial begin
      m_pc = 0; m_err = 0;
      rst = 1; stall = 0; jump = 0; branch = 0; call = 0; ret = 0;
      target = '0; offset = '0;

      // reset and wrap
      step(1,0,0,0,0,0,0,0);
      check("rst_pc", int'(pc), 0);
      check("rst_empty", int'(stk_empty), 1);
      for (int i = 1; i <= 3; i++) begin
         idle();
         check("inc_pc", int'(pc), i);
      end
      do_jump(1023);  check("jump_1023", int'(pc), 1023);
      idle();         check("wrap_0", int'(pc), 0);

      // branch
      do_jump(5);
      do_br(8'hFD);   check("br_m3", int'(pc), 2);
      do_br(8'hFB);   check("br_m5", int'(pc), 1021);
      do_br(8'h7F);   check("br_p127", int'(pc), 124);

      // nested call/return
      do_jump(10);
      do_call(100);   check("call1", int'(pc), 100);
      do_call(200);   check("call2", int'(pc), 200);
      do_ret();       check("ret1", int'(pc), 101);
      do_ret();       check("ret2", int'(pc), 11);
      check("nest_empty", int'(stk_empty), 1);
      check("nest_err", int'(err), 0);

      // overflow / underflow
      do_jump(300);
      for (int i = 0; i < 5; i++) begin
         do_call(400 + i);
         if (i == 3) check("full_after4", int'(stk_full), 1);
      end
      check("ovf_pc", int'(pc), 404);
      check("ovf_err", int'(err), 1);
      do_ret(); check("lifo0", int'(pc), 403);
      do_ret(); check("lifo1", int'(pc), 402);
      do_ret(); check("lifo2", int'(pc), 401);
      do_ret(); check("lifo3", int'(pc), 301);
      do_ret(); check("udf_pc", int'(pc), 302);
      check("udf_err", int'(err), 1);

      // priority and stall
      step(1,0,0,0,0,0,0,0);
      do_jump(50);
      do_call(60);
      step(0,1,1,1,1,0,123,0);  check("stall_pc", int'(pc), 60);
      check("stall_err", int'(err), 0);
      step(0,0,1,1,1,0,123,0);  check("ret_wins", int'(pc), 51);
      check("ret_wins_empty", int'(stk_empty), 1);
      step(0,0,0,0,1,1,77,8'h10); check("jump_over_br", int'(pc), 77);

      // reset during call: no push may survive
      do_call(20);
      step(1,0,0,1,0,0,90,0);
      check("midrst_pc", int'(pc), 0);
      check("midrst_empty", int'(stk_empty), 1);
      check("midrst_err", int'(err), 0);
      do_ret();
      check("midrst_nopush", int'(pc), 1);
      check("midrst_udf", int'(err), 1);

      // randomized traffic against the model
      step(1,0,0,0,0,0,0,0);
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, 255)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
